// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter
// Shares one bitwise logic unit (AND/OR/XOR/NOR) between two requesters.
// Requesters are arbitrated round-robin. The winner's op and operands are
// latched in IDLE and evaluated in EXEC. The tagged result is then held in
// RESP until the consumer accepts it.
module logic_unit_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic [CNTW-1:0]  grant_cnt0,
  output logic [CNTW-1:0]  grant_cnt1,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;

  // Shared bitwise logic unit; NOR covers the full operand width.
  function automatic logic [WIDTH-1:0] lu_compute(input logic [1:0]       op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = ~(a | b);
    endcase
    return r;
  endfunction

  // Saturating increment: a full counter stays at all-ones instead of wrapping.
  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
    logic [CNTW-1:0] r;
    if (c == {CNTW{1'b1}}) begin
      r = c;
    end else begin
      r = c + {{(CNTW-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  state_e           state_q,     state_d;
  logic             rr_ptr_q,    rr_ptr_d;
  logic [1:0]       op_q,        op_d;
  logic [WIDTH-1:0] a_q,         a_d;
  logic [WIDTH-1:0] b_q,         b_d;
  logic             id_q,        id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q,    rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q,  rsp_data_d;
  logic [CNTW-1:0]  cnt0_q,      cnt0_d;
  logic [CNTW-1:0]  cnt1_q,      cnt1_d;
  logic             busy_q,      busy_d;

  logic             grant_valid_s;
  logic             grant_id_s;
  logic [1:0]       sel_op_s;
  logic [WIDTH-1:0] sel_a_s;
  logic [WIDTH-1:0] sel_b_s;
  logic [WIDTH-1:0] lu_result_s;

  // Round-robin grant: only in IDLE, and rr_ptr breaks a tie.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_id_s    = 1'b0;
    if (state_q == ST_IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_valid_s = 1'b1;
        grant_id_s    = rr_ptr_q;
      end else if (req0_valid) begin
        grant_valid_s = 1'b1;
        grant_id_s    = 1'b0;
      end else if (req1_valid) begin
        grant_valid_s = 1'b1;
        grant_id_s    = 1'b1;
      end else begin
        grant_valid_s = 1'b0;
        grant_id_s    = 1'b0;
      end
    end else begin
      grant_valid_s = 1'b0;
      grant_id_s    = 1'b0;
    end
  end

  assign req0_ready = grant_valid_s & ~grant_id_s;
  assign req1_ready = grant_valid_s &  grant_id_s;

  // Operand mux: forward the granted requester's op and operands to the latches.
  always_comb begin
    sel_op_s = 2'b00;
    sel_a_s  = '0;
    sel_b_s  = '0;
    if (grant_id_s) begin
      sel_op_s = req1_op;
      sel_a_s  = req1_a;
      sel_b_s  = req1_b;
    end else begin
      sel_op_s = req0_op;
      sel_a_s  = req0_a;
      sel_b_s  = req0_b;
    end
  end

  assign lu_result_s = lu_compute(op_q, a_q, b_q);

  // Next-state logic for the IDLE -> EXEC -> RESP sequence.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    cnt0_d      = cnt0_q;
    cnt1_d      = cnt1_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid_s) begin
          state_d = ST_EXEC;
          op_d    = sel_op_s;
          a_d     = sel_a_s;
          b_d     = sel_b_s;
          id_d    = grant_id_s;
          if (grant_id_s) begin
            cnt1_d = sat_inc(cnt1_q);
          end else begin
            cnt0_d = sat_inc(cnt0_q);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        state_d     = ST_RESP;
        rsp_data_d  = lu_result_s;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          // Hand priority to the requester that was not just served.
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rr_ptr_d    = ~rsp_id_q;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset drops any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= 1'b0;
      op_q        <= 2'b00;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
      busy_q      <= busy_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
  assign busy       = busy_q;

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one 32-bit bitwise logic unit (AND/OR/XOR/NOR) between two requesters, e.g. the integer pipeline and the watermark/checksum engine.
- Arbitrates round-robin, latches operands, sequences one operation through the shared unit, and returns a tagged result over a valid/ready handshake.
- Sits beside the ALU in the soft processor datapath.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNTW, 16, width of the per-requester grant counters.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_ready  output  1  requester 0 operation accepted this cycle when high together with req0_valid.
- req0_op  input  2  op for requester 0: 00 AND, 01 OR, 10 XOR, 11 NOR.
- req0_a, req0_b  input  WIDTH  operands for requester 0.
- req1_valid, req1_ready, req1_op, req1_a, req1_b  as above, requester 1.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  1  requester that owns rsp_data.
- rsp_data  output  WIDTH  registered result.
- grant_cnt0, grant_cnt1  output  CNTW  saturating counts of accepted ops per requester.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, rst_n low): state=IDLE, rr_ptr=0 (requester 0 favoured), rsp_valid=0, rsp_id=0, rsp_data=0, grant counters=0, busy=0, operand/op latches=0.
- Any transaction in flight at reset is dropped. No response is produced for it.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req*_ready is combinational and is asserted only in IDLE, only for the granted requester.
  - Grant rule:
    - Only one valid: grant it.
    - Both valid: grant the requester selected by rr_ptr.
  - On accept (valid & ready): latch op, a, b and id; increment that requester's counter; go to EXEC.
  - Never more than one ready high per cycle.
- EXEC (1 cycle):
  - Compute the op on the latched operands through the shared unit.
  - Register rsp_data and rsp_id; set rsp_valid=1; go to RESP.
  - NOR = ~(a|b), full width.
- RESP:
  - rsp_valid, rsp_id and rsp_data are held stable until rsp_ready=1.
  - On handshake: rsp_valid=0; rr_ptr = ~rsp_id (the other requester gets priority next); go to IDLE.
  - No new accept in the handshake cycle.
- Timing:
  - Latency: accept at cycle T → rsp_valid high at T+2.
  - Minimum spacing between accepts: 3 cycles. With rsp_ready tied high, accepts occur at T, T+3, T+6, …
- Fairness: with both requesters continuously valid, grants strictly alternate.
- Counters saturate at 2^CNTW−1 and do not wrap.
- Request inputs are ignored outside IDLE. Changes to op or operands there have no effect on the in-flight result.
- rsp_ready asserted while rsp_valid=0 has no effect.
- busy = (state != IDLE).

Test Plan:
- Reset state: rst_n low mid-EXEC → rsp_valid, busy, counters and rsp_data go to 0 immediately (async). After release, the first request is accepted normally.
- Single requester: req0 op=00, a=0xF0F0_F0F0, b=0xFF00_FF00, rsp_ready=1 → rsp_valid at T+2 with rsp_data=0xF000_F000, rsp_id=0; grant_cnt0=1.
- All four ops: a=0x1234_5678, b=0x0F0F_0F0F.
  - OR → 0x1F3F_5F7F
  - XOR → 0x1D3B_5977
  - NOR → 0xE0C0_A080
  - AND → 0x0204_0608
- Contention: both valid continuously for 6 ops, rsp_ready=1 → rsp_id sequence 0,1,0,1,0,1; accepts 3 cycles apart; grant_cnt0=grant_cnt1=3.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid → rsp_data and rsp_id stable; both readies low throughout; accept resumes the cycle after the handshake.
- Saturation: with CNTW=2, 5 req1 ops → grant_cnt1 stops at 3.
